// File: rtl/barret_4027_pkg.sv
// rtl/barret_4027_pkg.sv - constants and reference model for the q = 4027 Barrett reducer
package barret_4027_pkg;

  localparam int Q     = 4027;
  localparam int MU    = 4166;
  localparam int SHIFT = 12;
  localparam int A_W   = 23;
  localparam int R_W   = 12;

  // Straight modulo, used as a golden model against the Barrett datapath.
  function automatic logic [R_W-1:0] ref_mod(input logic [A_W-1:0] a);
    return R_W'(a % A_W'(Q));
  endfunction

endpackage

// File: rtl/barret_pipe_4027.sv
// rtl/barret_pipe_4027.sv - three-stage Barrett reduction pipeline for q = 4027
module barret_pipe_4027
  import barret_4027_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_v,
  input  logic [ID_W-1:0] in_id,
  input  logic [A_W-1:0]  in_a,
  output logic            out_v,
  output logic [ID_W-1:0] out_id,
  output logic [R_W-1:0]  out_r,
  output logic [2:0]      stage_v
);

  logic            v1;
  logic [ID_W-1:0] id1;
  logic [A_W-1:0]  a1;
  logic [24:0]     qh1;

  logic            v2;
  logic [ID_W-1:0] id2;
  logic [23:0]     r2;

  logic [R_W-1:0]  sub_q;

  // S1: capture the operand and form the scaled quotient estimate at full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      id1 <= '0;
      a1  <= '0;
      qh1 <= '0;
    end else if (en) begin
      v1  <= in_v;
      id1 <= in_id;
      a1  <= in_a;
      qh1 <= 25'(in_a >> SHIFT) * 25'(MU);
    end
  end

  // S2: subtract the estimated multiple of q; the estimate never overshoots, so r stays non-negative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      id2 <= '0;
      r2  <= '0;
    end else if (en) begin
      v2  <= v1;
      id2 <= id1;
      r2  <= 24'({2'b00, a1} - ((qh1 >> SHIFT) * 25'(Q)));
    end
  end

  // Pick 0, q or 2q to remove; the final residue is below 4096, so 12-bit wraparound subtraction is exact.
  always_comb begin
    sub_q = '0;
    if (r2 >= 24'(2 * Q)) begin
      sub_q = R_W'(2 * Q);
    end else if (r2 >= 24'(Q)) begin
      sub_q = R_W'(Q);
    end
  end

  // S3: register the canonical residue and its requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      out_id <= '0;
      out_r  <= '0;
    end else if (en) begin
      out_v  <= v2;
      out_id <= id2;
      out_r  <= r2[R_W-1:0] - sub_q;
    end
  end

  assign stage_v = {out_v, v2, v1};

endmodule

// File: rtl/barret_arbiter_4027.sv
// rtl/barret_arbiter_4027.sv - round-robin front end sharing one mod-4027 reducer
module barret_arbiter_4027
  import barret_4027_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*A_W-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  output logic [R_W-1:0]      out_data,
  output logic [ID_W-1:0]     out_id,
  input  logic                out_ready,
  output logic                idle
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] ptr_nxt;
  logic            gnt_any;
  logic            en;
  logic [2:0]      stage_v;
  logic [A_W-1:0]  gnt_a;

  // The whole pipeline moves together; only a held result stops it.
  assign en = !out_valid || out_ready;

  // Round-robin search starting at ptr; no grant while stalled or held in reset.
  always_comb begin
    int idx;
    req_ready = '0;
    gnt_id    = '0;
    gnt_any   = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any        = 1'b1;
        gnt_id         = ID_W'(idx);
        req_ready[idx] = 1'b1;
      end
    end
    if (!en || !rst_n) begin
      req_ready = '0;
      gnt_any   = 1'b0;
    end
  end

  assign ptr_nxt = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  assign gnt_a   = req_data[A_W*gnt_id +: A_W];

  // Advance the pointer past the winner on every accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= ptr_nxt;
    end
  end

  barret_pipe_4027 #(
    .ID_W(ID_W)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .in_v   (gnt_any),
    .in_id  (gnt_id),
    .in_a   (gnt_a),
    .out_v  (out_valid),
    .out_id (out_id),
    .out_r  (out_data),
    .stage_v(stage_v)
  );

  assign idle = !(|stage_v);

endmodule

// File: tb/tb_barret_arbiter_4027.sv
// tb/tb_barret_arbiter_4027.sv - scoreboard bench for the shared mod-4027 reducer
module tb_barret_arbiter_4027;
  import barret_4027_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*23-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [11:0]   out_data;
  logic [1:0]    out_id;
  logic          out_ready;
  logic          idle;

  logic [22:0]   op [N];
  logic [11:0]   ev [N];

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  logic [2:0]    m_v;
  int            m_ptr;
  logic          m_en;
  logic [N-1:0]  exp_g;
  logic [N-1:0]  last_gnt;
  int            gid;

  barret_arbiter_4027 #(.NREQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready),
    .idle     (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < N; i++) req_data[23*i +: 23] = op[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor and occupancy/arbitration model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_v      = '0;
      m_ptr    = 0;
      last_gnt = '0;
      chk("reset_req_ready", req_ready, 0);
    end else begin
      chk("out_valid", out_valid, m_v[2]);
      chk("idle", idle, (m_v == 3'b000));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d data %0d expected none", out_id, out_data);
        end else begin
          chk("out_data", out_data, q[0].d);
          chk("out_id", out_id, q[0].id);
        end
      end
      m_en  = !m_v[2] || out_ready;
      exp_g = '0;
      gid   = -1;
      if (m_en) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (gid < 0 && req_valid[idx]) gid = idx;
        end
      end
      if (gid >= 0) exp_g[gid] = 1'b1;
      chk("req_ready", req_ready, exp_g);
      if (m_en) begin
        if (m_v[2] && q.size() > 0) void'(q.pop_front());
        m_v = {m_v[1:0], (gid >= 0)};
        if (gid >= 0) begin
          q.push_back('{id: 2'(gid), d: ev[gid]});
          m_ptr = (gid + 1) % N;
        end
      end
      last_gnt = exp_g;
    end
  end

  task automatic set_op(input int i, input logic [22:0] a, input logic [11:0] e);
    op[i] = a;
    ev[i] = e;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      done = idle && (q.size() == 0);
    end
    chk("drain_complete", done, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 23'd0, 12'd0);

    // Reset state, with all requesters pushing.
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_idle", idle, 1);
    chk("rst_req_ready", req_ready, 0);
    rst_n     = 1'b1;
    req_valid = '0;

    // Fairness: all four valid for 12 cycles.
    set_op(0, 23'd12345,   12'd264);
    set_op(1, 23'd100000,  12'd3352);
    set_op(2, 23'd4096,    12'd69);
    set_op(3, 23'd5000000, 12'd2493);
    step();
    req_valid = 4'b1111;
    repeat (12) step();
    req_valid = '0;
    wait_idle();

    // Single maximal operand from requester 0.
    set_op(0, 23'd8388607, 12'd366);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    wait_idle();

    // Boundary operands, one per cycle.
    req_valid = 4'b0001;
    set_op(0, 23'd0, 12'd0);       step();
    set_op(0, 23'd4026, 12'd4026); step();
    set_op(0, 23'd4027, 12'd0);    step();
    set_op(0, 23'd8054, 12'd0);    step();
    set_op(0, 23'd8053, 12'd4026); step();
    req_valid = 4'b0100;
    set_op(2, 23'd12080, 12'd4026); step();
    set_op(2, 23'd12081, 12'd0);    step();
    set_op(2, 23'd8056, 12'd2);     step();
    req_valid = '0;
    wait_idle();

    // Backpressure: fill the pipe, then stall.
    set_op(0, 23'd12345,   12'd264);
    set_op(1, 23'd7777777, 12'd1640);
    set_op(2, 23'd4096,    12'd69);
    set_op(3, 23'd5000000, 12'd2493);
    out_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (8) step();
    chk("stall_idle", idle, 0);
    chk("stall_req_ready", req_ready, 0);
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle();

    // Reset with three operations in flight.
    req_valid = 4'b1111;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_idle", idle, 1);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_req_ready", req_ready, 0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1100;
    step();
    req_valid = '0;
    wait_idle();

    // Random operands with random valid and consumer backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i] || !req_valid[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            req_valid[i] = 1'b1;
            op[i] = 23'($urandom_range(0, 8388607));
            ev[i] = ref_mod(op[i]);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
